dvs_event_scheduler: RTL and testbench

- Sits between dvs_aer_receiver and the RAVENS spike input.
- Buffers decoded DVS events and releases them downstream over a valid/ready handshake.
- Groups events into fixed-length time steps derived from timer_us time_us, and emits a step-advance pulse when each step closes.
- Sequences the receiver datapath into the processor's discrete-time schedule.

---
 rtl/dvs_ravens_pkg.sv | 20 ++
 rtl/dvs_event_fifo.sv | 54 +++++
 rtl/dvs_event_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dvs_event_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS receive path and the event scheduler.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS   = 8;
  localparam int DVS_Y_ADDR_BITS   = 8;
  localparam int TIMESTAMP_US_BITS = 32;

  localparam int SCHED_FIFO_DEPTH  = 16;
  localparam int SCHED_TIMESTEP_US = 1000;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
    logic                         polarity;
  } dvs_event_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous event FIFO; the head entry is visible combinationally on head_o.
module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = SCHED_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  dvs_event_t               din_i,
  input  logic                     pop_i,
  output dvs_event_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  dvs_event_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dvs_event_scheduler.sv
// Buffers DVS events and releases them per fixed time step over valid/ready.
// Define DVS_SCHED_LATE_DROP_EN to discard late events instead of emitting them.
module dvs_event_scheduler
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH  = SCHED_FIFO_DEPTH,
  parameter int TIMESTEP_US = SCHED_TIMESTEP_US,
  parameter int CNT_BITS    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [TIMESTAMP_US_BITS-1:0] time_us,
  input  logic                         new_event,
  input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
  input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
  input  logic                         event_polarity,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DVS_X_ADDR_BITS-1:0]   out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]   out_y,
  output logic                         out_polarity,
  output logic                         step_advance,
  output logic [CNT_BITS-1:0]          step_index,
  output logic                         busy,
  output logic [CNT_BITS-1:0]          overflow_count,
  output logic [CNT_BITS-1:0]          late_count
);

  localparam int TSB = TIMESTAMP_US_BITS;

  sched_state_t               state_q;
  logic [TSB-1:0]             window_start_q;
  logic [CNT_BITS-1:0]        step_index_q, overflow_q, late_q;
  logic [CNT_BITS-1:0]        overflow_d, late_d;
  logic                       step_adv_q, out_valid_q, out_late_q;
  logic [DVS_X_ADDR_BITS-1:0] out_x_q;
  logic [DVS_Y_ADDR_BITS-1:0] out_y_q;
  logic                       out_pol_q;

  dvs_event_t                 head, din;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [TSB-1:0]             head_delta, elapsed;
  logic                       head_cur, head_late;
  logic                       push_req, load, drop, accept, pop, pop_late, step_close;

  assign din = '{x: event_x, y: event_y, timestamp: event_timestamp, polarity: event_polarity};

  dvs_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Modular distances: the top bit of the delta marks a timestamp behind the window.
  assign head_delta = head.timestamp - window_start_q;
  assign elapsed    = time_us - window_start_q;
  assign head_late  = !fifo_empty && head_delta[TSB-1];
  assign head_cur   = !fifo_empty && !head_delta[TSB-1] && (head_delta < TSB'(TIMESTEP_US));

  assign push_req = new_event && (state_q == RUN);
  assign accept   = out_valid_q && out_ready;

  // The output register holds a copy of the head; the FIFO entry leaves on acceptance.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    if (!out_valid_q && !fifo_empty) begin
      if (state_q == DRAIN) begin
        load = 1'b1;
      end else if (state_q == RUN) begin
`ifdef DVS_SCHED_LATE_DROP_EN
        load = head_cur;
        drop = head_late;
`else
        load = head_cur || head_late;
`endif
      end
    end
  end

  assign pop        = accept || drop;
  assign pop_late   = accept ? out_late_q : drop;
  assign step_close = (state_q == RUN) && (elapsed >= TSB'(TIMESTEP_US)) &&
                      !out_valid_q && !head_cur && !head_late;

  assign overflow_d = (push_req && fifo_full && !pop && overflow_q != '1) ? overflow_q + 1'b1 : overflow_q;
  assign late_d     = (pop && pop_late && late_q != '1) ? late_q + 1'b1 : late_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      window_start_q <= '0;
      step_index_q   <= '0;
      overflow_q     <= '0;
      late_q         <= '0;
      step_adv_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_late_q     <= 1'b0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_pol_q      <= 1'b0;
    end else begin
      step_adv_q <= 1'b0;
      overflow_q <= overflow_d;
      late_q     <= late_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_late_q  <= head_late;
        out_x_q     <= head.x;
        out_y_q     <= head.y;
        out_pol_q   <= head.polarity;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (enable) begin
          state_q        <= RUN;
          window_start_q <= time_us;
          step_index_q   <= '0;
          overflow_q     <= '0;
          late_q         <= '0;
        end
        RUN: begin
          if (step_close) begin
            step_adv_q     <= 1'b1;
            step_index_q   <= step_index_q + 1'b1;
            window_start_q <= window_start_q + TSB'(TIMESTEP_US);
          end
          if (!enable) state_q <= DRAIN;
        end
        DRAIN: if (fifo_count == '0 && !out_valid_q) begin
          step_adv_q     <= 1'b1;
          step_index_q   <= step_index_q + 1'b1;
          window_start_q <= window_start_q + TSB'(TIMESTEP_US);
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign out_polarity   = out_pol_q;
  assign step_advance   = step_adv_q;
  assign step_index     = step_index_q;
  assign busy           = (state_q != IDLE);
  assign overflow_count = overflow_q;
  assign late_count     = late_q;

endmodule

// File: tb/tb_dvs_event_scheduler.sv
// Bench for dvs_event_scheduler: scoreboard of emitted events plus a classification vector table.
module tb_dvs_event_scheduler;
  import dvs_ravens_pkg::*;

  localparam int TSB = TIMESTAMP_US_BITS;
  localparam int XB  = DVS_X_ADDR_BITS;
  localparam int YB  = DVS_Y_ADDR_BITS;
  localparam int CNT_BITS = 16;

`ifdef DVS_SCHED_LATE_DROP_EN
  localparam bit LATE_EMIT = 1'b0;
`else
  localparam bit LATE_EMIT = 1'b1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, new_event = 1'b0;
  logic event_polarity = 1'b0, out_ready = 1'b0;
  logic [TSB-1:0] time_us = '0, event_timestamp = '0;
  logic [XB-1:0]  event_x = '0;
  logic [YB-1:0]  event_y = '0;
  logic           out_valid, out_polarity, step_advance, busy;
  logic [XB-1:0]  out_x;
  logic [YB-1:0]  out_y;
  logic [CNT_BITS-1:0] step_index, overflow_count, late_count;

  dvs_event_scheduler #(.FIFO_DEPTH(16), .TIMESTEP_US(1000), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .time_us(time_us),
    .new_event(new_event), .event_x(event_x), .event_y(event_y),
    .event_timestamp(event_timestamp), .event_polarity(event_polarity),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_polarity(out_polarity), .step_advance(step_advance), .step_index(step_index),
    .busy(busy), .overflow_count(overflow_count), .late_count(late_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          pol;
  } exp_t;

  typedef struct {
    logic [TSB-1:0] en_t;
    logic [TSB-1:0] ts;
    bit             emit;
    bit             future;
    int             late;
  } vec_t;

  exp_t sb_q[$];
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_adv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every presented event must match the scoreboard head, stalled or not.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: got x=%0d y=%0d, expected no event", out_x, out_y);
        if (out_ready) n_acc++;
      end else begin
        check("out_x", out_x, sb_q[0].x);
        check("out_y", out_y, sb_q[0].y);
        check("out_pol", out_polarity, sb_q[0].pol);
        if (out_ready) begin
          $display("event accepted: x=%0d y=%0d pol=%0d step=%0d", out_x, out_y, out_polarity, step_index);
          void'(sb_q.pop_front());
          n_acc++;
        end
      end
    end
    if (rst_n && step_advance) n_adv++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic [XB-1:0] x, input logic [YB-1:0] y,
                         input logic [TSB-1:0] ts, input logic pol, input bit expect_out);
    exp_t e;
    new_event = 1'b1; event_x = x; event_y = y; event_timestamp = ts; event_polarity = pol;
    if (expect_out) begin
      e.x = x; e.y = y; e.pol = pol;
      sb_q.push_back(e);
    end
    @(negedge clk);
    new_event = 1'b0;
  endtask

  task automatic wait_adv(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (step_advance) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check(name, idle, 1'b1);
  endtask

  task automatic wait_acc(input string name, input int target, input int limit);
    for (int i = 0; i < limit && n_acc < target; i++) @(negedge clk);
    check(name, n_acc, target);
  endtask

  initial begin
    vec_t vecs[8];
    int a0, d0;

    vecs[0] = '{en_t: 32'd100,        ts: 32'd150,        emit: 1'b1,      future: 1'b0, late: 0};
    vecs[1] = '{en_t: 32'd100,        ts: 32'd1099,       emit: 1'b1,      future: 1'b0, late: 0};
    vecs[2] = '{en_t: 32'd100,        ts: 32'd1100,       emit: 1'b0,      future: 1'b1, late: 0};
    vecs[3] = '{en_t: 32'hFFFF_FE0C,  ts: 32'd200,        emit: 1'b1,      future: 1'b0, late: 0};
    vecs[4] = '{en_t: 32'hFFFF_FE0C,  ts: 32'hFFFF_FDA8,  emit: LATE_EMIT, future: 1'b0, late: 1};
    vecs[5] = '{en_t: 32'd5000,       ts: 32'd4999,       emit: LATE_EMIT, future: 1'b0, late: 1};
    vecs[6] = '{en_t: 32'd5000,       ts: 32'h8000_1387,  emit: 1'b0,      future: 1'b1, late: 0};
    vecs[7] = '{en_t: 32'd5000,       ts: 32'h8000_1388,  emit: LATE_EMIT, future: 1'b0, late: 1};

    // Reset state
    tick(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_step_adv", step_advance, 0);
    check("rst_step_index", step_index, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow_count, 0);
    check("rst_late", late_count, 0);
    rst_n = 1'b1;
    tick(1);

    // Basic emission, latency and first step close
    time_us = 100; enable = 1'b1; out_ready = 1'b1;
    tick(1);
    check("run_busy", busy, 1);
    check("run_step_index", step_index, 0);
    time_us = 150;
    push_ev(8'd1, 8'd2, 32'd150, 1'b1, 1'b1);
    check("latency_n1", out_valid, 0);
    tick(1);
    check("latency_n2", out_valid, 1);
    tick(2);
    time_us = 400;
    push_ev(8'd3, 8'd4, 32'd400, 1'b0, 1'b1);
    tick(4);
    check("basic_accepted", n_acc, 2);
    time_us = 1100;
    wait_adv("adv_at_1100", 6);
    check("step_index_1", step_index, 1);
    tick(1);
    check("adv_one_cycle", step_advance, 0);

    // Future event held until its step opens
    time_us = 1200;
    push_ev(8'd5, 8'd6, 32'd2150, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("future_held", out_valid, 0);
      tick(1);
    end
    a0 = n_acc;
    time_us = 2150;
    wait_adv("adv_at_2150", 6);
    check("step_index_2", step_index, 2);
    wait_acc("future_emitted", a0 + 1, 8);

    // Overflow with downstream stalled, then a randomly stalled drain
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      logic [XB-1:0] xi;
      xi = XB'(i);
      push_ev(xi, 8'd100 + xi, 32'd2100 + 32'(3 * i), xi[0], i < 16);
    end
    tick(2);
    check("overflow_count", overflow_count, 1);
    check("stall_valid", out_valid, 1);
    a0 = n_acc;
    for (int k = 0; k < 400 && n_acc < a0 + 16; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    out_ready = 1'b1;
    check("overflow_drained", n_acc - a0, 16);
    check("overflow_sb_empty", sb_q.size(), 0);

    // Drain of buffered future events
    a0 = n_acc; d0 = n_adv;
    push_ev(8'd20, 8'd21, 32'd3300, 1'b0, 1'b1);
    push_ev(8'd22, 8'd23, 32'd3400, 1'b1, 1'b1);
    push_ev(8'd24, 8'd25, 32'd3500, 1'b0, 1'b1);
    tick(2);
    check("drain_pre_valid", out_valid, 0);
    enable = 1'b0;
    wait_idle("drain_to_idle", 40);
    tick(3);
    check("drain_emitted", n_acc - a0, 3);
    check("drain_one_adv", n_adv - d0, 1);
    check("drain_step_index", step_index, 3);

    // new_event in IDLE is ignored
    a0 = n_acc;
    time_us = 2150;
    push_ev(8'd9, 8'd9, 32'd2150, 1'b0, 1'b0);
    enable = 1'b1;
    tick(5);
    check("idle_push_ignored", n_acc - a0, 0);
    enable = 1'b0;
    wait_idle("idle_test_to_idle", 10);

    // Classification vectors, each in a fresh run
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      time_us = vecs[i].en_t; enable = 1'b1;
      tick(1);
      a0 = n_acc;
      push_ev(XB'(i), YB'(i + 50), vecs[i].ts, 1'b1, vecs[i].emit);
      tick(4);
      check($sformatf("vec%0d_emit", i), n_acc - a0, 32'(vecs[i].emit));
      check($sformatf("vec%0d_late", i), late_count, vecs[i].late);
      if (vecs[i].future) begin
        e.x = XB'(i); e.y = YB'(i + 50); e.pol = 1'b1;
        sb_q.push_back(e);
      end
      enable = 1'b0;
      wait_idle($sformatf("vec%0d_idle", i), 20);
      tick(2);
      check($sformatf("vec%0d_sb_empty", i), sb_q.size(), 0);
    end

    // Reset in the middle of a stalled handshake
    time_us = 7000; enable = 1'b1; out_ready = 1'b0;
    tick(1);
    push_ev(8'd7, 8'd7, 32'd7000, 1'b1, 1'b1);
    tick(1);
    check("rst_mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_step_index", step_index, 0);
    check("rst_mid_overflow", overflow_count, 0);
    check("rst_mid_late", late_count, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    a0 = n_acc;
    tick(6);
    check("rst_fifo_empty", n_acc - a0, 0);
    check("rst_after_valid", out_valid, 0);
    enable = 1'b0;
    wait_idle("final_idle", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
